// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a single UART transmitter core.
// Runs the txbegin/txbusy handshake and aborts a start the core never takes.
module uart_tx_arbiter #(
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned TMO_W      = 8,
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] ack,
    output logic [7:0] uart_txdata,
    output logic       uart_txbegin,
    input  logic       uart_txbusy,
    output logic       owner,
    output logic       busy,
    output logic       tmo_err
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DRAIN
    } state_e;

    // Abort fires on the edge where the counter would reach TMO_CYCLES.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [7:0]       txdata_q, txdata_d;
    logic [1:0]       ack_q, ack_d;
    logic             txbegin_q, txbegin_d;
    logic             owner_q, owner_d;
    logic             tmo_q, tmo_d;
    logic             gnt_vld;
    logic             gnt_idx;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (!uart_txbusy && ack_q == 2'b00) begin
            unique case (req)
                2'b01: begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b0;
                end
                2'b10: begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b1;
                end
                2'b11: begin
                    gnt_vld = 1'b1;
                    gnt_idx = (FIXED_PRIO != 0) ? 1'b0 : ~owner_q;
                end
                default: begin
                    gnt_vld = 1'b0;
                    gnt_idx = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        txdata_d  = txdata_q;
        ack_d     = 2'b00;
        txbegin_d = txbegin_q;
        owner_d   = owner_q;
        tmo_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                txbegin_d = 1'b0;
                if (gnt_vld) begin
                    txdata_d       = gnt_idx ? data1 : data0;
                    owner_d        = gnt_idx;
                    ack_d[gnt_idx] = 1'b1;
                    txbegin_d      = 1'b1;
                    cnt_d          = '0;
                    state_d        = START;
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (uart_txbusy) begin
                    txbegin_d = 1'b0;
                    state_d   = DRAIN;
                end else if (cnt_q == TMO_LAST) begin
                    txbegin_d = 1'b0;
                    tmo_d     = 1'b1;
                    state_d   = IDLE;
                end
            end
            DRAIN: begin
                txbegin_d = 1'b0;
                if (!uart_txbusy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                txbegin_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            txdata_q  <= 8'h00;
            ack_q     <= 2'b00;
            txbegin_q <= 1'b0;
            owner_q   <= 1'b1;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            txdata_q  <= txdata_d;
            ack_q     <= ack_d;
            txbegin_q <= txbegin_d;
            owner_q   <= owner_d;
            tmo_q     <= tmo_d;
        end
    end

    assign ack          = ack_q;
    assign uart_txdata  = txdata_q;
    assign uart_txbegin = txbegin_q;
    assign owner        = owner_q;
    assign tmo_err      = tmo_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: round-robin instance [0] and fixed-priority instance [1]
// share all inputs; expectations are hand-computed per scenario.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       txbusy = 1'b0;

    logic [1:0] ack_a [2];
    logic [7:0] txd_a [2];
    logic       txb_a [2];
    logic       own_a [2];
    logic       bsy_a [2];
    logic       tmo_a [2];

    int n_run = 0;
    int n_fail = 0;
    int n_ack1_fp = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req),
        .data0(data0), .data1(data1), .ack(ack_a[0]),
        .uart_txdata(txd_a[0]), .uart_txbegin(txb_a[0]),
        .uart_txbusy(txbusy), .owner(own_a[0]),
        .busy(bsy_a[0]), .tmo_err(tmo_a[0])
    );

    uart_tx_arbiter #(.FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .req(req),
        .data0(data0), .data1(data1), .ack(ack_a[1]),
        .uart_txdata(txd_a[1]), .uart_txbegin(txb_a[1]),
        .uart_txbusy(txbusy), .owner(own_a[1]),
        .busy(bsy_a[1]), .tmo_err(tmo_a[1])
    );

    always @(negedge clk) begin
        if (mon_en && ack_a[1][1]) n_ack1_fp++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n  = 1'b0;
        txbusy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits for a grant on instance d, then plays one core frame.
    task automatic xfer(input int d, input logic [7:0] ed, input logic eo,
                        input logic [1:0] ea, input string tag);
        int n;
        n = 0;
        tick;
        while (ack_a[d] == 2'b00 && n < 10) begin
            tick;
            n++;
        end
        chk({tag, "_ack"}, 32'(ack_a[d]), 32'(ea));
        chk({tag, "_data"}, 32'(txd_a[d]), 32'(ed));
        chk({tag, "_owner"}, 32'(own_a[d]), 32'(eo));
        tick;
        txbusy = 1'b1;
        tick;
        chk({tag, "_drain"}, 32'(txb_a[d]), 32'd0);
        repeat (3) tick;
        txbusy = 1'b0;
        tick;
        chk({tag, "_idle"}, 32'(bsy_a[d]), 32'd0);
    endtask

    initial begin
        int cnt;

        // Reset values
        #12;
        chk("rst_ack", 32'(ack_a[0]), 32'd0);
        chk("rst_txd", 32'(txd_a[0]), 32'd0);
        chk("rst_txb", 32'(txb_a[0]), 32'd0);
        chk("rst_owner", 32'(own_a[0]), 32'd1);
        chk("rst_busy", 32'(bsy_a[0]), 32'd0);
        chk("rst_tmo", 32'(tmo_a[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request
        tick;
        req   = 2'b01;
        data0 = 8'h41;
        tick;
        chk("single_ack", 32'(ack_a[0]), 32'h1);
        chk("single_txd", 32'(txd_a[0]), 32'h41);
        chk("single_txb1", 32'(txb_a[0]), 32'd1);
        chk("single_owner", 32'(own_a[0]), 32'd0);
        req = 2'b00;
        tick;
        chk("single_ackpulse", 32'(ack_a[0]), 32'd0);
        chk("single_txb2", 32'(txb_a[0]), 32'd1);
        txbusy = 1'b1;
        tick;
        chk("single_txb_off", 32'(txb_a[0]), 32'd0);
        repeat (19) tick;
        chk("single_busy_hold", 32'(bsy_a[0]), 32'd1);
        txbusy = 1'b0;
        tick;
        chk("single_busy_end", 32'(bsy_a[0]), 32'd0);
        chk("single_txd_held", 32'(txd_a[0]), 32'h41);

        // Round-robin tie
        do_reset;
        data0 = 8'h10;
        data1 = 8'h20;
        req   = 2'b11;
        xfer(0, 8'h10, 1'b0, 2'b01, "rr0");
        xfer(0, 8'h20, 1'b1, 2'b10, "rr1");
        xfer(0, 8'h10, 1'b0, 2'b01, "rr2");
        xfer(0, 8'h20, 1'b1, 2'b10, "rr3");
        req = 2'b00;

        // Fixed priority
        do_reset;
        mon_en = 1'b1;
        req    = 2'b11;
        xfer(1, 8'h10, 1'b0, 2'b01, "fp0");
        xfer(1, 8'h10, 1'b0, 2'b01, "fp1");
        xfer(1, 8'h10, 1'b0, 2'b01, "fp2");
        req = 2'b00;
        tick;
        mon_en = 1'b0;
        chk("fp_no_ack1", 32'(n_ack1_fp), 32'd0);

        // Watchdog
        do_reset;
        req   = 2'b10;
        data1 = 8'h55;
        tick;
        chk("wd_ack", 32'(ack_a[0]), 32'h2);
        chk("wd_txd", 32'(txd_a[0]), 32'h55);
        req = 2'b00;
        cnt = (txb_a[0] == 1'b1) ? 1 : 0;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (txb_a[0]) cnt++;
            else break;
        end
        chk("wd_txb_len", 32'(cnt), 32'd255);
        chk("wd_tmo", 32'(tmo_a[0]), 32'd1);
        chk("wd_idle", 32'(bsy_a[0]), 32'd0);
        tick;
        chk("wd_tmo_pulse", 32'(tmo_a[0]), 32'd0);
        chk("wd_still_idle", 32'(bsy_a[0]), 32'd0);

        // Core already busy
        do_reset;
        txbusy = 1'b1;
        req    = 2'b01;
        data0  = 8'h33;
        repeat (3) tick;
        chk("cb_no_ack", 32'(ack_a[0]), 32'd0);
        chk("cb_no_txb", 32'(txb_a[0]), 32'd0);
        chk("cb_idle", 32'(bsy_a[0]), 32'd0);
        txbusy = 1'b0;
        tick;
        chk("cb_ack", 32'(ack_a[0]), 32'h1);
        chk("cb_txb", 32'(txb_a[0]), 32'd1);
        chk("cb_txd", 32'(txd_a[0]), 32'h33);
        req = 2'b00;
        tick;
        txbusy = 1'b1;
        tick;
        txbusy = 1'b0;
        tick;
        chk("cb_done", 32'(bsy_a[0]), 32'd0);

        // Reset mid-transfer
        req   = 2'b01;
        data0 = 8'h7e;
        tick;
        chk("rm_owner0", 32'(own_a[0]), 32'd0);
        req = 2'b00;
        tick;
        txbusy = 1'b1;
        tick;
        chk("rm_drain", 32'(bsy_a[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_txb", 32'(txb_a[0]), 32'd0);
        chk("rm_ack", 32'(ack_a[0]), 32'd0);
        chk("rm_busy", 32'(bsy_a[0]), 32'd0);
        chk("rm_owner", 32'(own_a[0]), 32'd1);
        txbusy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick;
        chk("rm_post_busy", 32'(bsy_a[0]), 32'd0);
        chk("rm_post_ack", 32'(ack_a[0]), 32'd0);
        chk("rm_post_txb", 32'(txb_a[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART core transmitter between two byte requesters.
  - Requester 0: CPU register port.
  - Requester 1: on-chip console/loader source.
- Sequences the core's txbegin/txbusy handshake: holds txbegin until the core reports busy, then waits for busy to drop.
- Sits between the requesters and the uart core's txdata/txbegin/txbusy pins.
- Round-robin or fixed-priority arbitration, with a watchdog for a core that never starts.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin; 1 = requester 0 always wins a tie.
- TMO_W, 8: width of the start-watchdog counter.
- TMO_CYCLES, 255: START cycles allowed before abort. Must be ≤ 2^TMO_W − 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester request level; held high with stable data until the matching ack.
- data0  in  8  byte from requester 0.
- data1  in  8  byte from requester 1.
- ack  out  2  one-cycle pulse: byte of that requester latched.
- uart_txdata  out  8  byte to the uart core.
- uart_txbegin  out  1  start request to the uart core.
- uart_txbusy  in  1  core transmitter busy.
- owner  out  1  index of the last granted requester.
- busy  out  1  high whenever state ≠ IDLE.
- tmo_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async, rst_n=0), all registered:
  - state=IDLE.
  - ack=00, uart_txdata=00, uart_txbegin=0, owner=1 (so requester 0 wins the first round-robin tie), tmo_err=0, watchdog counter=0.
  - A reset mid-transfer drops txbegin immediately. No ack is replayed.
- All outputs are registered. busy is decoded from the state register.
- FSM states: IDLE, START, DRAIN.
- IDLE:
  - No grant while uart_txbusy=1, while req=00, or in the cycle an ack is being output.
  - Single request: grant that requester.
  - Both requesting, FIXED_PRIO=1: grant 0.
  - Both requesting, FIXED_PRIO=0: grant the index ≠ owner.
  - On grant at edge N: uart_txdata←granted data; owner←index; ack[index]=1 for cycle N+1 only; uart_txbegin←1; counter←0; state←START.
  - The requester must drop req or change data in the cycle it sees ack.
  - Since ack is registered, the IDLE cycle after a DRAIN exit ignores the previous requester only if it still shows ack. A requester that keeps req high after ack is granted again at the next arbitration.
- START:
  - uart_txbegin stays 1 and the counter increments each cycle.
  - uart_txbusy=1: uart_txbegin←0, state←DRAIN.
  - Counter reaches TMO_CYCLES with uart_txbusy still 0: uart_txbegin←0, tmo_err pulse 1 cycle, state←IDLE. The byte is lost; ack has already been given.
  - If txbusy rises in the same cycle the counter hits TMO_CYCLES, txbusy wins (go to DRAIN, no error).
- DRAIN:
  - uart_txbegin=0. Wait for uart_txbusy=0, then state←IDLE.
  - No timeout in DRAIN.
- uart_txdata is held constant from grant until the next grant.
- Minimum spacing between ack pulses: 3 cycles (IDLE→START→DRAIN→IDLE).
- req changes during START/DRAIN are ignored until IDLE.
- Throughput: one byte per core frame. No buffering; back-pressure is via withheld ack.

Test Plan:
- Single request: reset; req=01, data0=0x41; core raises txbusy 2 cycles after txbegin, holds it 20 cycles. Required: ack=01 for one cycle, uart_txdata=0x41, txbegin high exactly 2 cycles, busy low again 1 cycle after txbusy falls, owner=0.
- Round-robin tie: FIXED_PRIO=0; req=11 held, data0=0x10, data1=0x20, both requesters re-request after each ack. Required: grant sequence 0x10, 0x20, 0x10, 0x20; owner alternates 0,1,0,1.
- Fixed priority: FIXED_PRIO=1; req=11 held for 3 transfers. Required: three ack[0] pulses, ack[1] never asserted.
- Watchdog: tie uart_txbusy=0; req=10, data1=0x55. Required: ack=10, txbegin high for 255 cycles, tmo_err pulse on the following cycle, state back to IDLE, no DRAIN entry.
- Core already busy: uart_txbusy=1 before req=01. Required: no ack and no txbegin until txbusy falls; grant on the next edge after it falls.
- Reset mid-transfer: assert rst_n=0 while in DRAIN. Required: txbegin=0, ack=00, busy=0, owner=1 asynchronously. After release with req=00, outputs stay idle.
